free_list_ctrl: RTL

Physical-register free-list controller for the rename stage. Holds every unmapped physical register index in a circular queue, hands one out per cycle to rename for destination allocation, and takes registers back when commit retires the previous mapping. Sits between rename (allocator), the busy table (marks new registers busy) and the commit path (releases registers).

---
 rtl/qu_common_pkg.sv | 16 +
 rtl/qu_circ_fifo.sv | 74 +++++++
 rtl/free_list_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/qu_common_pkg.sv
// Shared rename-stage constants and types for the physical register file.
package qu_common;

  localparam int PHY_RF_ADDR_WIDTH = 6;
  localparam int PHY_RF_COUNT      = 2 ** PHY_RF_ADDR_WIDTH;
  localparam int ARCH_REG_COUNT    = 32;

  typedef logic [PHY_RF_ADDR_WIDTH-1:0] phy_reg_addr_t;
  typedef logic [PHY_RF_ADDR_WIDTH:0]   free_count_t;

  // Physical register 0 is hard-wired to x0 and may never return to the free list.
  function automatic logic is_x0(input phy_reg_addr_t addr);
    return (addr == phy_reg_addr_t'(0));
  endfunction

endpackage

// File: rtl/qu_circ_fifo.sv
// Generic single-push/single-pop circular queue; after reset it holds
// RESET_COUNT entries valued RESET_BASE, RESET_BASE+1, ...
module qu_circ_fifo #(
  parameter int DEPTH       = 64,
  parameter int WIDTH       = 6,
  parameter int RESET_BASE  = 32,
  parameter int RESET_COUNT = 32,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [AW:0]      count_r;
  logic             empty_r;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;
  logic [AW:0]      count_next_s;

  // Qualify push/pop against occupancy and derive the next count.
  always_comb begin
    full_s       = (count_r == (AW+1)'(DEPTH));
    do_push_s    = push & ~full_s;
    do_pop_s     = pop & ~empty_r;
    count_next_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_next_s = count_r + (AW+1)'(1);
    end else if (!do_push_s && do_pop_s) begin
      count_next_s = count_r - (AW+1)'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Storage, pointers and occupancy; head==tail is disambiguated by count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= (i < RESET_COUNT) ? WIDTH'(RESET_BASE + i) : {WIDTH{1'b0}};
      end
      head_r  <= {AW{1'b0}};
      tail_r  <= AW'(RESET_COUNT);
      count_r <= (AW+1)'(RESET_COUNT);
      empty_r <= (RESET_COUNT == 0);
    end else begin
      if (do_push_s) begin
        mem_r[tail_r] <= push_data;
        tail_r        <= tail_r + AW'(1);
      end
      if (do_pop_s) begin
        head_r <= head_r + AW'(1);
      end
      count_r <= count_next_s;
      empty_r <= (count_next_s == (AW+1)'(0));
    end
  end

  assign head_data = mem_r[head_r];
  assign count     = count_r;
  assign empty     = empty_r;
  assign full      = full_s;

endmodule

// File: rtl/free_list_ctrl.sv
// Rename-stage physical register free list with x0 filtering.
// Build option QU_FREE_LIST_CHECK_EN adds a free bitmap that drops double releases.
module free_list_ctrl
  import qu_common::*;
#(
  parameter int PHY_RF_DEPTH = PHY_RF_COUNT,
  parameter int ARCH_REGS    = ARCH_REG_COUNT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_req_in,
  output logic          alloc_grant_out,
  output phy_reg_addr_t alloc_addr_out,
  input  logic          release_en_in,
  input  phy_reg_addr_t release_addr_in,
  output logic          busy_set_en_out,
  output phy_reg_addr_t busy_set_addr_out,
  output free_count_t   free_count_out,
  output logic          empty_out,
  output logic          dbl_release_err_out
);

  phy_reg_addr_t head_entry_s;
  free_count_t   count_s;
  logic          empty_s;
  logic          full_s;
  logic          grant_s;
  logic          release_ok_s;
  logic          push_s;

  // Zero-latency grant; a same-cycle release never bypasses into an empty list.
  always_comb begin
    grant_s      = alloc_req_in & ~empty_s;
    release_ok_s = release_en_in & ~is_x0(release_addr_in) & ~full_s;
  end

`ifdef QU_FREE_LIST_CHECK_EN
  logic [PHY_RF_DEPTH-1:0] free_map_r;
  logic                    dbl_err_r;
  logic                    dbl_s;

  // A release hitting an already-free register is a double release.
  always_comb begin
    dbl_s  = release_ok_s & free_map_r[release_addr_in];
    push_s = release_ok_s & ~free_map_r[release_addr_in];
  end

  // Free bitmap tracking plus sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHY_RF_DEPTH; i++) begin
        free_map_r[i] <= (i >= ARCH_REGS);
      end
      dbl_err_r <= 1'b0;
    end else begin
      if (grant_s) begin
        free_map_r[head_entry_s] <= 1'b0;
      end
      if (push_s) begin
        free_map_r[release_addr_in] <= 1'b1;
      end
      if (dbl_s) begin
        dbl_err_r <= 1'b1;
      end
    end
  end

  assign dbl_release_err_out = dbl_err_r;
`else
  assign push_s              = release_ok_s;
  assign dbl_release_err_out = 1'b0;
`endif

  qu_circ_fifo #(
    .DEPTH      (PHY_RF_DEPTH),
    .WIDTH      (PHY_RF_ADDR_WIDTH),
    .RESET_BASE (ARCH_REGS),
    .RESET_COUNT(PHY_RF_DEPTH - ARCH_REGS)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .push_data(release_addr_in),
    .pop      (grant_s),
    .head_data(head_entry_s),
    .count    (count_s),
    .empty    (empty_s),
    .full     (full_s)
  );

  assign alloc_grant_out   = grant_s;
  assign alloc_addr_out    = head_entry_s;
  assign busy_set_en_out   = grant_s;
  assign busy_set_addr_out = head_entry_s;
  assign free_count_out    = count_s;
  assign empty_out         = empty_s;

endmodule
